// File: rtl/ycc_to_rgb_pipe.sv
// Full-range YCbCr to signed, unclamped RGB: 3 register stages, one pixel per clock.
// A stalled output (o_valid & !i_ready) freezes every stage; optional tag sideband under YCC_TAG_PASSTHRU_EN.
module ycc_to_rgb_pipe #(
  parameter int FRAC = 8,
  parameter int OUTW = 16,
  parameter int KRV  = 359,
  parameter int KGU  = 88,
  parameter int KGV  = 183,
  parameter int KBU  = 454,
  parameter int TAGW = 4
) (
  input  logic                   clk,
  input  logic                   nRst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [7:0]             i_Y,
  input  logic [7:0]             i_Cb,
  input  logic [7:0]             i_Cr,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic signed [OUTW-1:0] o_R,
  output logic signed [OUTW-1:0] o_G,
  output logic signed [OUTW-1:0] o_B
`ifdef YCC_TAG_PASSTHRU_EN
  ,
  input  logic [TAGW-1:0]        i_tag,
  output logic [TAGW-1:0]        o_tag
`endif
);

  // Headroom: coefficient (< 2^(FRAC+1)) times 8-bit chroma plus the luma term, with a spare bit.
  localparam int PW = FRAC + 12;

  localparam logic signed [PW-1:0] KRV_C = PW'(KRV);
  localparam logic signed [PW-1:0] KGU_C = PW'(KGU);
  localparam logic signed [PW-1:0] KGV_C = PW'(KGV);
  localparam logic signed [PW-1:0] KBU_C = PW'(KBU);
  localparam logic signed [PW-1:0] RND_C = PW'(1) <<< (FRAC - 1);

  if (OUTW < 10 || TAGW < 1) begin : g_param_chk
    $error("ycc_to_rgb_pipe: OUTW must be >= 10 and TAGW >= 1");
  end

  logic adv;

  logic                   v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [7:0]             y1_q, y1_d;
  logic signed [8:0]      cb1_q, cb1_d, cr1_q, cr1_d;
  logic signed [PW-1:0]   r2_q, r2_d, g2_q, g2_d, b2_q, b2_d, yb2_q, yb2_d;
  logic signed [OUTW-1:0] r3_q, r3_d, g3_q, g3_d, b3_q, b3_d;

  logic signed [PW-1:0]   cb_ext, cr_ext;
  logic signed [PW-1:0]   r_sum, g_sum, b_sum;

  always_comb begin
    adv    = !v3_q || i_ready;

    cb_ext = PW'(cb1_q);
    cr_ext = PW'(cr1_q);
    r_sum  = yb2_q + r2_q;
    g_sum  = yb2_q + g2_q;
    b_sum  = yb2_q + b2_q;

    v1_d   = v1_q;
    y1_d   = y1_q;
    cb1_d  = cb1_q;
    cr1_d  = cr1_q;
    v2_d   = v2_q;
    r2_d   = r2_q;
    g2_d   = g2_q;
    b2_d   = b2_q;
    yb2_d  = yb2_q;
    v3_d   = v3_q;
    r3_d   = r3_q;
    g3_d   = g3_q;
    b3_d   = b3_q;

    // Data registers load on every advance, valid or not; only valid-qualified values matter.
    if (adv) begin
      v1_d  = i_valid;
      y1_d  = i_Y;
      cb1_d = 9'(i_Cb) - 9'd128;
      cr1_d = 9'(i_Cr) - 9'd128;

      v2_d  = v1_q;
      r2_d  = KRV_C * cr_ext;
      g2_d  = -((KGU_C * cb_ext) + (KGV_C * cr_ext));
      b2_d  = KBU_C * cb_ext;
      yb2_d = $signed(PW'(y1_q) << FRAC) + RND_C;

      // Arithmetic shift floors; the half-LSB in yb2 turns that into round-half-up.
      v3_d  = v2_q;
      r3_d  = OUTW'(r_sum >>> FRAC);
      g3_d  = OUTW'(g_sum >>> FRAC);
      b3_d  = OUTW'(b_sum >>> FRAC);
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      v1_q  <= 1'b0;
      y1_q  <= '0;
      cb1_q <= '0;
      cr1_q <= '0;
      v2_q  <= 1'b0;
      r2_q  <= '0;
      g2_q  <= '0;
      b2_q  <= '0;
      yb2_q <= '0;
      v3_q  <= 1'b0;
      r3_q  <= '0;
      g3_q  <= '0;
      b3_q  <= '0;
    end else begin
      v1_q  <= v1_d;
      y1_q  <= y1_d;
      cb1_q <= cb1_d;
      cr1_q <= cr1_d;
      v2_q  <= v2_d;
      r2_q  <= r2_d;
      g2_q  <= g2_d;
      b2_q  <= b2_d;
      yb2_q <= yb2_d;
      v3_q  <= v3_d;
      r3_q  <= r3_d;
      g3_q  <= g3_d;
      b3_q  <= b3_d;
    end
  end

  assign o_ready = adv;
  assign o_valid = v3_q;
  assign o_R     = r3_q;
  assign o_G     = g3_q;
  assign o_B     = b3_q;

`ifdef YCC_TAG_PASSTHRU_EN
  logic [TAGW-1:0] t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;

  always_comb begin
    t1_d = t1_q;
    t2_d = t2_q;
    t3_d = t3_q;
    if (adv) begin
      t1_d = i_tag;
      t2_d = t1_q;
      t3_d = t2_q;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      t1_q <= '0;
      t2_q <= '0;
      t3_q <= '0;
    end else begin
      t1_q <= t1_d;
      t2_q <= t2_d;
      t3_q <= t3_d;
    end
  end

  assign o_tag = t3_q;
`endif

endmodule
